// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame serializer.
// FFT_SER_BITREV_EN selects bit-reversed read order in the top.
package fft_pkg;

  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int SHIFT = 8;

  typedef struct packed {
    logic signed [IN_W-1:0] re;
    logic signed [IN_W-1:0] im;
  } point_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] bitrev4(
    input logic [IDX_W-1:0] k
  );
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_frame_serializer_if.sv
// Frame-in / point-out handshake bundle.
// slave is the serializer side, master the upstream/downstream side.
interface fft_frame_serializer_if;
  import fft_pkg::*;

  logic                  frame_valid;
  logic                  frame_ready;
  logic [N*2*IN_W-1:0]   frame_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*OUT_W-1:0]    out_data;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  out_ready,
    output frame_ready,
    output out_valid,
    output out_data,
    output out_index,
    output out_last
  );

  modport master (
    output frame_valid,
    output frame_data,
    output out_ready,
    input  frame_ready,
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last
  );

endinterface

// File: rtl/fft_round_sat.sv
// Round-half-up, arithmetic shift and saturate of one component.
// Q16.16 in, Q8.8 out.
module fft_round_sat
  import fft_pkg::*;
(
  input  logic signed [IN_W-1:0]  i_x,
  output logic signed [OUT_W-1:0] o_y
);

  localparam logic signed [IN_W:0] RND =
    (IN_W+1)'(1 << (SHIFT-1));
  localparam logic signed [IN_W:0] MAXV =
    (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] MINV =
    (IN_W+1)'(-(1 << (OUT_W-1)));

  logic signed [IN_W:0] w_sum;
  logic signed [IN_W:0] w_t;

  // One guard bit keeps the rounding add from wrapping.
  assign w_sum = $signed({i_x[IN_W-1], i_x}) + RND;
  assign w_t   = w_sum >>> SHIFT;

  always_comb begin
    o_y = w_t[OUT_W-1:0];
    if (w_t > MAXV) begin
      o_y = MAXV[OUT_W-1:0];
    end else if (w_t < MINV) begin
      o_y = MINV[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fft_frame_serializer.sv
// Captures a 16-point frame and streams it one point per cycle.
// FFT_SER_BITREV_EN: read buffer[bitrev4(k)] instead of buffer[k].
module fft_frame_serializer
  import fft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  fft_frame_serializer_if.slave  io_bus
);

  state_t r_state;
  state_t w_next;

  point_t             r_buf [N];
  logic [IDX_W-1:0]   r_k;
  logic               r_valid;
  logic               r_last;
  logic [2*OUT_W-1:0] r_data;

  logic w_fire;
  logic w_take;
  logic w_load;
  logic w_adv;
  logic w_done;

  logic [IDX_W-1:0]        w_sel_k;
  logic [IDX_W-1:0]        w_addr;
  point_t                  w_pt;
  logic signed [OUT_W-1:0] w_re;
  logic signed [OUT_W-1:0] w_im;

  assign w_fire = r_valid & io_bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_load = 1'b0;
    w_adv  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (io_bus.frame_valid) begin
          w_take = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_load = 1'b1;
        w_next = STREAM;
      end
      STREAM: begin
        if (w_fire) begin
          if (r_k == IDX_W'(N-1)) begin
            w_done = 1'b1;
            w_next = IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Point about to be presented: 0 on load, k+1 on advance.
  assign w_sel_k = w_load ? '0 : r_k + 1'b1;

`ifdef FFT_SER_BITREV_EN
  assign w_addr = bitrev4(w_sel_k);
`else
  assign w_addr = w_sel_k;
`endif

  assign w_pt = r_buf[w_addr];

  fft_round_sat u_rs_re (
    .i_x (w_pt.re),
    .o_y (w_re)
  );

  fft_round_sat u_rs_im (
    .i_x (w_pt.im),
    .o_y (w_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < N; p++) begin
        r_buf[p] <= '0;
      end
    end else if (w_take) begin
      for (int p = 0; p < N; p++) begin
        r_buf[p] <= point_t'(io_bus.frame_data[p*2*IN_W +: 2*IN_W]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_take) begin
        r_k <= '0;
      end
      if (w_load || w_adv) begin
        r_k     <= w_sel_k;
        r_valid <= 1'b1;
        r_data  <= {w_re, w_im};
        r_last  <= (w_sel_k == IDX_W'(N-1));
      end
      if (w_done) begin
        r_k     <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign io_bus.frame_ready = (r_state == IDLE);
  assign io_bus.out_valid   = r_valid;
  assign io_bus.out_data    = r_data;
  assign io_bus.out_index   = r_k;
  assign io_bus.out_last    = r_last;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Scoreboard bench for fft_frame_serializer.
// Expected order follows FFT_SER_BITREV_EN as the DUT is built.
module tb_fft_frame_serializer;
  import fft_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  i;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_serializer_if bus();

  fft_frame_serializer dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  beat_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] map(int k);
    logic [3:0] kk;
    kk = 4'(k);
`ifdef FFT_SER_BITREV_EN
    return {kk[0], kk[1], kk[2], kk[3]};
`else
    return kk;
`endif
  endfunction

  // point p = {(p+off)<<16, -(p<<16)}; optional raw point 0
  function automatic logic [1023:0] mk_frame(
    int off, bit use0, logic [63:0] p0);
    logic [1023:0] f;
    for (int p = 0; p < 16; p++) begin
      f[p*64 +: 64] = {32'((p + off) << 16), 32'(-(p << 16))};
    end
    if (use0) f[63:0] = p0;
    return f;
  endfunction

  task automatic push_exp(int off, bit use0, logic [31:0] d0);
    beat_t b;
    int idx;
    for (int k = 0; k < 16; k++) begin
      idx = int'(map(k));
      b.d = {16'((idx + off) * 256), 16'(-idx * 256)};
      if (use0 && k == 0) b.d = d0;
      b.i = 4'(k);
      b.l = (k == 15);
      q.push_back(b);
    end
  endtask

  // Monitor: pops a beat on every accepted output
  logic  pv = 1'b0;
  logic  pr = 1'b0;
  beat_t pb;
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {bus.out_data, bus.out_index, bus.out_last};
    if (!rst && bus.out_valid) begin
      if (pv && !pr) chk("hold", 64'(cur), 64'(pb));
      chk("busy_ready", 64'(bus.frame_ready), 64'd0);
      if (bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %0h want none", cur);
        end else begin
          e = q.pop_front();
          chk("beat", 64'(cur), 64'(e));
        end
      end
    end
    pv = bus.out_valid && !rst;
    pr = bus.out_ready;
    pb = cur;
  end

  int hs_cyc = 0;

  task automatic send(logic [1023:0] f);
    int n;
    n = 0;
    bus.frame_data  = f;
    bus.frame_valid = 1'b1;
    while (!bus.frame_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("hs_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    hs_cyc = cyc;
    bus.frame_valid = 1'b0;
    chk("lat_load", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_first", 64'(bus.out_valid), 64'd1);
    chk("first_idx", 64'(bus.out_index), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    chk("ready_back", 64'(bus.frame_ready), 64'd1);
    chk("idle_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic wait_idx(int k);
    int n;
    n = 0;
    while (!(bus.out_valid && bus.out_index == 4'(k)) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idx", 64'(n < 64), 64'd1);
  endtask

  initial begin
    int hs_a;
    logic [31:0] k1;
    logic [31:0] k3;
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    bus.out_ready   = 1'b1;
    #12;
    chk("rst_ready", 64'(bus.frame_ready), 64'd1);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_index", 64'(bus.out_index), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef FFT_SER_BITREV_EN
    k1 = 32'h0800_F800;
    k3 = 32'h0C00_F400;
`else
    k1 = 32'h0100_FF00;
    k3 = 32'h0300_FD00;
`endif
    // Ramp frame
    push_exp(0, 1'b0, '0);
    send(mk_frame(0, 1'b0, '0));
    chk("k0_data", 64'(bus.out_data), 64'h0);
    wait_idx(1);
    chk("k1_data", 64'(bus.out_data), 64'(k1));
    wait_idx(3);
    chk("k3_data", 64'(bus.out_data), 64'(k3));
    drain();

    // Saturation and rounding on point 0
    push_exp(0, 1'b1, 32'h7FFF_8000);
    send(mk_frame(0, 1'b1, 64'h7FFF0000_80000000));
    drain();
    push_exp(0, 1'b1, 32'h0001_0000);
    send(mk_frame(0, 1'b1, 64'h00000080_FFFFFF80));
    drain();
    push_exp(0, 1'b1, 32'h7FFF_8000);
    send(mk_frame(0, 1'b1, 64'h007FFF80_FF800000));
    drain();
    push_exp(0, 1'b1, 32'h0001_FFFF);
    send(mk_frame(0, 1'b1, 64'h0000017F_FFFFFE80));
    drain();

    // Back-pressure at k=5
    push_exp(3, 1'b0, '0);
    send(mk_frame(3, 1'b0, '0));
    wait_idx(5);
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_idx", 64'(bus.out_index), 64'd5);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_next", 64'(bus.out_index), 64'd6);
    drain();

    // Reset mid-stream at k=7
    push_exp(0, 1'b0, '0);
    send(mk_frame(0, 1'b0, '0));
    wait_idx(7);
    rst = 1'b1;
    #1;
    chk("mrst_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_ready", 64'(bus.frame_ready), 64'd1);
    chk("mrst_index", 64'(bus.out_index), 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(5, 1'b0, '0);
    send(mk_frame(5, 1'b0, '0));
    drain();

    // Back-to-back frames with frame_valid held
    push_exp(0, 1'b0, '0);
    send(mk_frame(0, 1'b0, '0));
    hs_a = hs_cyc;
    push_exp(16, 1'b0, '0);
    bus.frame_data  = mk_frame(16, 1'b0, '0);
    bus.frame_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.frame_ready && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_timeout", 64'(n < 100), 64'd1);
    end
    chk("b2b_a_done", 64'(q.size()), 64'd16);
    @(posedge clk); #1;
    bus.frame_valid = 1'b0;
    chk("b2b_period", 64'(cyc - hs_a), 64'd18);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
